// File: rtl/counter_sequencer.sv
// Command sequencer for a loadable up/down counter.
// Commands {start value, step count, direction} are queued in a small FIFO.
// Each one is run as load -> count for N clocks -> report the final count.
module counter_sequencer #(
  parameter int BIT_WIDTH  = 4,
  parameter int STEP_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BIT_WIDTH-1:0]  cmd_load,
  input  logic [STEP_WIDTH-1:0] cmd_steps,
  input  logic                  cmd_dir,
  input  logic                  abort,
  output logic                  cnt_load_en,
  output logic [BIT_WIDTH-1:0]  cnt_load,
  output logic                  cnt_en,
  output logic                  chnge,
  input  logic [BIT_WIDTH-1:0]  cnt_value,
  output logic                  busy,
  output logic                  done,
  output logic [BIT_WIDTH-1:0]  done_value,
  output logic                  wrap
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = BIT_WIDTH + STEP_WIDTH + 1;
  localparam logic [AW:0]         PTR_ONE  = 1;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty;
  logic                  push, pop;
  logic [EW-1:0]         head;

  logic [BIT_WIDTH-1:0]  cur_load;
  logic [STEP_WIDTH-1:0] cur_steps;
  logic                  cur_dir;
  logic [STEP_WIDTH-1:0] steps_left;
  logic [BIT_WIDTH-1:0]  done_value_q;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready is blocked while a flush is requested, so no push is lost to it.
  assign cmd_ready = !full && !abort && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty && !abort;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  // FIFO pointers: abort empties the queue by rewinding both pointers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage: written at the write pointer on every accepted command.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {cmd_load, cmd_steps, cmd_dir};
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; abort always returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = LOAD;
      LOAD:    next_state = (cur_steps == '0) ? FINISH : RUN;
      RUN:     if (steps_left <= STEP_ONE) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Current command registers, captured when the head is popped in IDLE.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cur_load  <= '0;
      cur_steps <= '0;
      cur_dir   <= 1'b0;
    end else if (pop) begin
      {cur_load, cur_steps, cur_dir} <= head;
    end
  end

  // Remaining enabled clocks; loaded in LOAD and never taken below zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      steps_left <= '0;
    end else if (state == LOAD) begin
      steps_left <= cur_steps;
    end else if (state == RUN && steps_left != '0) begin
      steps_left <= steps_left - STEP_ONE;
    end
  end

  // Completion value is held here between done pulses.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)     done_value_q <= '0;
    else if (done) done_value_q <= cnt_value;
  end

  // Counter control and status outputs, decoded from registered state.
  always_comb begin
    cnt_load_en = (state == LOAD);
    cnt_en      = (state == RUN);
    cnt_load    = cur_load;
    chnge       = cur_dir;
    done        = (state == FINISH) && !abort;
    done_value  = done ? cnt_value : done_value_q;
    busy        = (state != IDLE) || !empty;
    wrap        = cnt_en && ((chnge && cnt_value == '1) || (!chnge && cnt_value == '0));
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with a behavioural 4-bit counter.
module tb_counter_sequencer;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_load = '0;
  logic [7:0] cmd_steps = '0;
  logic       cmd_dir = 1'b0;
  logic       abort = 1'b0;
  logic       cnt_load_en;
  logic [3:0] cnt_load;
  logic       cnt_en;
  logic       chnge;
  logic [3:0] cnt_value;
  logic       busy;
  logic       done;
  logic [3:0] done_value;
  logic       wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];

  counter_sequencer #(.BIT_WIDTH(4), .STEP_WIDTH(8), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort),
    .cnt_load_en(cnt_load_en), .cnt_load(cnt_load), .cnt_en(cnt_en), .chnge(chnge),
    .cnt_value(cnt_value), .busy(busy), .done(done), .done_value(done_value), .wrap(wrap)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Cycle index; at a falling edge it names the cycle in progress.
  always @(posedge CLK) cyc = cyc + 1;

  // The counter the sequencer drives.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)            cnt_value <= 4'd0;
    else if (cnt_load_en) cnt_value <= cnt_load;
    else if (cnt_en)      cnt_value <= chnge ? cnt_value + 4'd1 : cnt_value - 4'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] finalCount(input logic [3:0] ld, input logic [7:0] st, input logic dir);
    logic [3:0] s;
    s = st[3:0];
    return dir ? ld + s : ld - s;
  endfunction

  // Scoreboard: expected done values queued at acceptance, compared at done.
  always @(negedge CLK) begin
    if (reset || abort) begin
      exp_q.delete();
    end else begin
      if (done) begin
        if (exp_q.size() == 0) checkOutput("unexpected_done", 1, 0);
        else checkOutput("sb_done_value", done_value, exp_q.pop_front());
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(finalCount(cmd_load, cmd_steps, cmd_dir));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one command and hold it until accepted; entered just after a rising edge.
  task automatic applyStimulus(input logic [3:0] ld, input logic [7:0] st, input logic dir,
                               output int acc_cyc, output int stalls);
    bit ok;
    ok = 0;
    stalls = 0;
    acc_cyc = -1;
    cmd_valid = 1'b1;
    cmd_load = ld;
    cmd_steps = st;
    cmd_dir = dir;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        acc_cyc = cyc;
        ok = 1;
      end else begin
        stalls++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  // Follow one command to its done pulse, collecting what the counter saw.
  task automatic watchCommand(input logic exp_dir, output int load_cyc, output int en_cnt,
                              output int wrap_cnt, output int wrap_val, output int done_cyc,
                              output int done_val, output int chnge_bad);
    bit fin;
    fin = 0;
    load_cyc = -1; en_cnt = 0; wrap_cnt = 0; wrap_val = -1;
    done_cyc = -1; done_val = -1; chnge_bad = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge CLK);
      if (cnt_load_en && load_cyc < 0) load_cyc = cyc;
      if (cnt_en) en_cnt++;
      if (wrap) begin
        wrap_cnt++;
        wrap_val = int'(cnt_value);
      end
      if (load_cyc >= 0 && chnge !== exp_dir) chnge_bad++;
      if (done) begin
        done_cyc = cyc;
        done_val = int'(done_value);
        fin = 1;
      end
    end
    if (!fin) checkOutput("done_timeout", 0, 1);
    tick();
  endtask

  task automatic waitRunCycles(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge CLK);
      if (cnt_en) seen++;
    end
    if (seen < n) checkOutput("run_timeout", seen, n);
    tick();
  endtask

  int t, st, lc, ec, wc, wv, dc, dv, cb;
  int st4[4];
  int dcyc[4];
  int ndone;

  initial begin
    // Reset state.
    @(negedge CLK);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ctrl", {cnt_load_en, cnt_en, chnge, wrap}, 0);
    checkOutput("rst_values", {cnt_load, done_value}, 0);
    tick();
    reset = 1'b0;
    @(negedge CLK);
    checkOutput("ready_after_reset", cmd_ready, 1);
    tick();

    // Up count through the top of the range.
    applyStimulus(4'd12, 8'd5, 1'b1, t, st);
    watchCommand(1'b1, lc, ec, wc, wv, dc, dv, cb);
    checkOutput("t1_load_cycle", lc - t, 2);
    checkOutput("t1_en_count", ec, 5);
    checkOutput("t1_wrap_count", wc, 1);
    checkOutput("t1_wrap_value", wv, 15);
    checkOutput("t1_done_cycle", dc - t, 8);
    checkOutput("t1_done_value", dv, 1);
    checkOutput("t1_chnge", cb, 0);
    @(negedge CLK);
    checkOutput("t1_done_value_hold", done_value, 1);
    checkOutput("t1_idle", busy, 0);
    tick();

    // Down count through zero.
    applyStimulus(4'd2, 8'd4, 1'b0, t, st);
    watchCommand(1'b0, lc, ec, wc, wv, dc, dv, cb);
    checkOutput("t2_en_count", ec, 4);
    checkOutput("t2_wrap_count", wc, 1);
    checkOutput("t2_wrap_value", wv, 0);
    checkOutput("t2_done_value", dv, 14);
    checkOutput("t2_chnge_down", cb, 0);

    // Zero-step command goes straight from LOAD to FINISH.
    applyStimulus(4'd9, 8'd0, 1'b1, t, st);
    watchCommand(1'b1, lc, ec, wc, wv, dc, dv, cb);
    checkOutput("t3_load_cycle", lc - t, 2);
    checkOutput("t3_en_count", ec, 0);
    checkOutput("t3_done_cycle", dc - t, 3);
    checkOutput("t3_done_value", dv, 9);

    // Four commands with valid held: the FIFO fills and back-pressures.
    ndone = 0;
    fork
      begin
        applyStimulus(4'd1, 8'd2, 1'b1, t, st4[0]);
        applyStimulus(4'd3, 8'd1, 1'b0, t, st4[1]);
        applyStimulus(4'd7, 8'd3, 1'b0, t, st4[2]);
        applyStimulus(4'd8, 8'd2, 1'b1, t, st4[3]);
      end
      begin
        for (int i = 0; i < 200 && ndone < 4; i++) begin
          @(negedge CLK);
          if (done) begin
            dcyc[ndone] = cyc;
            ndone++;
          end
        end
      end
    join
    checkOutput("t4_done_count", ndone, 4);
    checkOutput("t4_backpressure", (st4[0] + st4[1] + st4[2] + st4[3]) > 0, 1);
    checkOutput("t4_gap_b", dcyc[1] - dcyc[0], 4);
    checkOutput("t4_gap_c", dcyc[2] - dcyc[1], 6);
    checkOutput("t4_gap_d", dcyc[3] - dcyc[2], 5);
    tick();
    checkOutput("t4_done_value", done_value, 10);

    // Abort mid-run with one command queued behind it.
    applyStimulus(4'd0, 8'd10, 1'b1, t, st);
    applyStimulus(4'd4, 8'd2, 1'b1, t, st);
    waitRunCycles(3);
    abort = 1'b1;
    @(negedge CLK);
    checkOutput("t5_ready_in_abort", cmd_ready, 0);
    tick();
    abort = 1'b0;
    @(negedge CLK);
    checkOutput("t5_en_dropped", {cnt_en, cnt_load_en}, 0);
    checkOutput("t5_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    checkOutput("t5_no_done", ndone, 0);
    checkOutput("t5_done_value_kept", done_value, 10);
    tick();

    // Abort while idle and empty changes nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge CLK);
    checkOutput("t5_idle_abort", {busy, cmd_ready, done_value}, {1'b0, 1'b1, 4'd10});
    tick();

    // Reset mid-run clears outputs without waiting for a clock.
    applyStimulus(4'd3, 8'd20, 1'b1, t, st);
    waitRunCycles(2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_clear", {cnt_en, cnt_load_en, busy, done, cmd_ready, wrap}, 0);
    checkOutput("t6_async_values", {done_value, cnt_load, chnge}, 0);
    @(negedge CLK);
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(4'd5, 8'd1, 1'b1, t, st);
    watchCommand(1'b1, lc, ec, wc, wv, dc, dv, cb);
    checkOutput("t6_done_value", dv, 6);
    checkOutput("t6_en_count", ec, 1);

    repeat (3) tick();
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 1, expected 0");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
